load_store_unit: RTL



---
 rtl/load_store_unit_pkg.sv | 22 ++
 rtl/lsu_lane_align.sv | 52 +++++
 rtl/load_store_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings and helpers for the load/store unit.
package load_store_unit_pkg;

   localparam logic [1:0] MASK_BYTE = 2'b00;
   localparam logic [1:0] MASK_HALF = 2'b01;
   localparam logic [1:0] MASK_WORD = 2'b10;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACC0 = 2'd1;
   localparam logic [1:0] ACC1 = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   // maskSel 11 behaves as a word access.
   function automatic logic [1:0] norm_width(input logic [1:0] sel);
      return (sel == MASK_BYTE || sel == MASK_HALF) ? sel : MASK_WORD;
   endfunction

   function automatic logic is_split(input logic [1:0] width, input logic [1:0] off);
      return (width == MASK_HALF && off == 2'd3) || (width == MASK_WORD && off != 2'd0);
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane placement for stores and extraction/extension for loads over a two-word window.
module lsu_lane_align
   import load_store_unit_pkg::*;
(
   input  logic [1:0]  off_i,
   input  logic [1:0]  width_i,
   input  logic        uext_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] lo_i,
   input  logic [31:0] hi_i,
   output logic [3:0]  be_lo_o,
   output logic [3:0]  be_hi_o,
   output logic [31:0] wd_lo_o,
   output logic [31:0] wd_hi_o,
   output logic [31:0] rdata_o
);

   logic [3:0]  mask;
   logic [7:0]  be64;
   logic [63:0] wd64;
   logic [31:0] win;
   logic        sgn;

   always_comb begin
      unique case (width_i)
         MASK_BYTE: mask = 4'b0001;
         MASK_HALF: mask = 4'b0011;
         default:   mask = 4'b1111;
      endcase
      be64 = {4'b0000, mask} << off_i;
      wd64 = {32'h0, wdata_i} << {off_i, 3'b000};
      be_lo_o = be64[3:0];
      be_hi_o = be64[7:4];
      wd_lo_o = wd64[31:0];
      wd_hi_o = wd64[63:32];

      win = 32'({hi_i, lo_i} >> {off_i, 3'b000});
      sgn = 1'b0;
      unique case (width_i)
         MASK_BYTE: begin
            sgn     = ~uext_i & win[7];
            rdata_o = {{24{sgn}}, win[7:0]};
         end
         MASK_HALF: begin
            sgn     = ~uext_i & win[15];
            rdata_o = {{16{sgn}}, win[15:0]};
         end
         default: rdata_o = win;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: word-aligned bus transactions, misaligned split, load extension.
// Splitting of misaligned accesses is built only when LSU_MISALIGNED_SPLIT_EN is defined.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memRd,
   input  logic              memWr,
   input  logic [1:0]        maskSel,
   input  logic              uext,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wrData,
   output logic [DATA_W-1:0] rdData,
   output logic              stall,
   output logic              misaligned,
   output logic [ADDR_W-1:0] busAddr,
   output logic [DATA_W-1:0] busWrData,
   output logic [3:0]        busByteEn,
   output logic              busWe,
   output logic              busReq,
   input  logic              busAck,
   input  logic [DATA_W-1:0] busRdData
);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        width_q, width_d;
   logic              uext_q, uext_d;
   logic              we_q, we_d;
   logic              split_q, split_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] rd_q, rd_d;

   logic [3:0]        be_lo, be_hi;
   logic [DATA_W-1:0] wd_lo, wd_hi, ld_data;
   logic [ADDR_W-1:0] base_addr;
   logic              start;

   lsu_lane_align u_align (
      .off_i   (addr_q[1:0]),
      .width_i (width_q),
      .uext_i  (uext_q),
      .wdata_i (wdata_q),
      .lo_i    (lo_q),
      .hi_i    (hi_q),
      .be_lo_o (be_lo),
      .be_hi_o (be_hi),
      .wd_lo_o (wd_lo),
      .wd_hi_o (wd_hi),
      .rdata_o (ld_data)
   );

   assign start     = memRd | memWr;
   assign base_addr = {addr_q[ADDR_W-1:2], 2'b00};

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      width_d = width_q;
      uext_d  = uext_q;
      we_d    = we_q;
      split_d = split_q;
      wdata_d = wdata_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               addr_d  = addr;
               width_d = norm_width(maskSel);
               uext_d  = uext;
               we_d    = memWr;
               split_d = is_split(norm_width(maskSel), addr[1:0]);
               wdata_d = wrData;
               hi_d    = '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
               state_d = ACC0;
`else
               state_d = is_split(norm_width(maskSel), addr[1:0]) ? DONE : ACC0;
`endif
            end
         end
         ACC0: begin
            if (busAck) begin
               lo_d = busRdData;
`ifdef LSU_MISALIGNED_SPLIT_EN
               state_d = split_q ? ACC1 : DONE;
`else
               state_d = DONE;
`endif
            end
         end
`ifdef LSU_MISALIGNED_SPLIT_EN
         ACC1: begin
            if (busAck) begin
               hi_d    = busRdData;
               state_d = DONE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busReq     = (state_q == ACC0) || (state_q == ACC1);
      busWe      = busReq && we_q;
      busAddr    = '0;
      busByteEn  = 4'b0000;
      busWrData  = '0;
      if (state_q == ACC0) begin
         busAddr   = base_addr;
         busByteEn = be_lo;
         busWrData = wd_lo;
      end else if (state_q == ACC1) begin
         busAddr   = base_addr + ADDR_W'(4);
         busByteEn = be_hi;
         busWrData = wd_hi;
      end
      misaligned = (state_q == DONE) && split_q;
      stall      = start && (state_q != DONE) && !reset;
      rd_d       = rd_q;
      if (state_q == DONE) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
         if (!we_q) rd_d = ld_data;
`else
         // A split access without split support never reached the bus.
         if (split_q) rd_d = '0;
         else if (!we_q) rd_d = ld_data;
`endif
      end
      rdData = rd_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         width_q <= MASK_BYTE;
         uext_q  <= 1'b0;
         we_q    <= 1'b0;
         split_q <= 1'b0;
         wdata_q <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         width_q <= width_d;
         uext_q  <= uext_d;
         we_q    <= we_d;
         split_q <= split_d;
         wdata_q <= wdata_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         rd_q    <= rd_d;
      end
   end

endmodule
